// File: rtl/data_table_search_bounded_if.sv
// Handshake and RAM-port bundle for the bounded hash-chain search engine.
// The master modport is the search engine side; slave is its environment.
interface data_table_search_bounded_if #(
  parameter int KEY_WIDTH    = 32,
  parameter int VALUE_WIDTH  = 16,
  parameter int A_WIDTH      = 10,
  parameter int BUCKET_WIDTH = 10,
  parameter int TAG_WIDTH    = 4,
  parameter int MAX_HOPS     = 16
);
  localparam int HW = $clog2(MAX_HOPS + 1);

  logic [KEY_WIDTH-1:0]    task_key_i;
  logic [BUCKET_WIDTH-1:0] task_bucket_i;
  logic [TAG_WIDTH-1:0]    task_tag_i;
  logic [A_WIDTH-1:0]      task_head_ptr_i;
  logic                    task_head_ptr_val_i;
  logic                    task_valid_i;
  logic                    task_ready_o;

  logic                    rd_avail_i;
  logic                    rd_en_o;
  logic [A_WIDTH-1:0]      rd_addr_o;
  logic                    rd_data_val_i;
  logic [KEY_WIDTH-1:0]    rd_key_i;
  logic [VALUE_WIDTH-1:0]  rd_value_i;
  logic [A_WIDTH-1:0]      rd_next_ptr_i;
  logic                    rd_next_ptr_val_i;

  logic [KEY_WIDTH-1:0]    result_key_o;
  logic [BUCKET_WIDTH-1:0] result_bucket_o;
  logic [TAG_WIDTH-1:0]    result_tag_o;
  logic [VALUE_WIDTH-1:0]  result_value_o;
  logic [1:0]              result_rescode_o;
  logic [2:0]              result_chain_state_o;
  logic [HW-1:0]           result_hops_o;
  logic                    result_valid_o;
  logic                    result_ready_i;

  modport master (
    input  task_key_i, task_bucket_i, task_tag_i, task_head_ptr_i, task_head_ptr_val_i,
    input  task_valid_i,
    output task_ready_o,
    input  rd_avail_i,
    output rd_en_o, rd_addr_o,
    input  rd_data_val_i, rd_key_i, rd_value_i, rd_next_ptr_i, rd_next_ptr_val_i,
    output result_key_o, result_bucket_o, result_tag_o, result_value_o,
    output result_rescode_o, result_chain_state_o, result_hops_o, result_valid_o,
    input  result_ready_i
  );

  modport slave (
    output task_key_i, task_bucket_i, task_tag_i, task_head_ptr_i, task_head_ptr_val_i,
    output task_valid_i,
    input  task_ready_o,
    output rd_avail_i,
    input  rd_en_o, rd_addr_o,
    output rd_data_val_i, rd_key_i, rd_value_i, rd_next_ptr_i, rd_next_ptr_val_i,
    input  result_key_o, result_bucket_o, result_tag_o, result_value_o,
    input  result_rescode_o, result_chain_state_o, result_hops_o, result_valid_o,
    output result_ready_i
  );
endinterface

// File: rtl/data_table_search_bounded.sv
// Walks a linked hash chain in external RAM looking for a key, one read per
// entry, giving up after MAX_HOPS entries.
module data_table_search_bounded #(
  parameter int KEY_WIDTH    = 32,
  parameter int VALUE_WIDTH  = 16,
  parameter int A_WIDTH      = 10,
  parameter int BUCKET_WIDTH = 10,
  parameter int TAG_WIDTH    = 4,
  parameter int MAX_HOPS     = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  data_table_search_bounded_if.master   bus
);
  localparam int HW = $clog2(MAX_HOPS + 1);
  localparam logic [HW-1:0] MAX_H = HW'(MAX_HOPS);
  localparam logic [HW-1:0] ONE_H = HW'(1);

  localparam logic [1:0] RC_FOUND = 2'd0, RC_NO_ENTRY = 2'd1, RC_TOO_LONG = 2'd2;
  localparam logic [2:0] CS_NO_CHAIN = 3'd0, CS_HEAD = 3'd1, CS_MIDDLE = 3'd2,
                         CS_TAIL = 3'd3, CS_TAIL_NO_MATCH = 3'd4, CS_ABORTED = 3'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

  state_t                  state;
  logic [A_WIDTH-1:0]      rd_addr;
  logic [HW-1:0]           hops;
  logic [KEY_WIDTH-1:0]    lk_key;
  logic [BUCKET_WIDTH-1:0] lk_bucket;
  logic [TAG_WIDTH-1:0]    lk_tag;
  logic [VALUE_WIDTH-1:0]  res_value;
  logic [1:0]              res_code;
  logic [2:0]              res_chain;

  function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] h);
    return (h == MAX_H) ? h : h + ONE_H;
  endfunction

  // A match on the first entry is always IN_HEAD, whatever follows it.
  function automatic logic [2:0] found_chain_state(input logic [HW-1:0] h, input logic nxt_val);
    if (h <= ONE_H) return CS_HEAD;
    return nxt_val ? CS_MIDDLE : CS_TAIL;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      rd_addr   <= '0;
      hops      <= '0;
      lk_key    <= '0;
      lk_bucket <= '0;
      lk_tag    <= '0;
      res_value <= '0;
      res_code  <= '0;
      res_chain <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.task_valid_i) begin
            lk_key    <= bus.task_key_i;
            lk_bucket <= bus.task_bucket_i;
            lk_tag    <= bus.task_tag_i;
            hops      <= '0;
            res_value <= '0;
            res_code  <= RC_NO_ENTRY;
            res_chain <= CS_NO_CHAIN;
            if (bus.task_head_ptr_val_i) begin
              rd_addr <= bus.task_head_ptr_i;
              state   <= ST_REQ;
            end else begin
              state   <= ST_DONE;
            end
          end
        end
        ST_REQ: begin
          if (bus.rd_avail_i) begin
            hops  <= sat_inc(hops);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.rd_data_val_i) begin
            // Match is tested before the hop limit so the last permitted entry can still hit.
            if (bus.rd_key_i == lk_key) begin
              res_code  <= RC_FOUND;
              res_chain <= found_chain_state(hops, bus.rd_next_ptr_val_i);
              res_value <= bus.rd_value_i;
              state     <= ST_DONE;
            end else if (!bus.rd_next_ptr_val_i) begin
              res_code  <= RC_NO_ENTRY;
              res_chain <= CS_TAIL_NO_MATCH;
              state     <= ST_DONE;
            end else if (hops == MAX_H) begin
              res_code  <= RC_TOO_LONG;
              res_chain <= CS_ABORTED;
              state     <= ST_DONE;
            end else begin
              rd_addr <= bus.rd_next_ptr_i;
              state   <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          if (bus.result_ready_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.task_ready_o         = (state == ST_IDLE) && !rst_i;
  assign bus.rd_en_o              = (state == ST_REQ);
  assign bus.rd_addr_o            = rd_addr;
  assign bus.result_valid_o       = (state == ST_DONE);
  assign bus.result_key_o         = lk_key;
  assign bus.result_bucket_o      = lk_bucket;
  assign bus.result_tag_o         = lk_tag;
  assign bus.result_value_o       = res_value;
  assign bus.result_rescode_o     = res_code;
  assign bus.result_chain_state_o = res_chain;
  assign bus.result_hops_o        = hops;
endmodule

// File: tb/tb_data_table_search_bounded.sv
// Randomized bench for data_table_search_bounded: RAM responder with random
// latency/availability plus a chain-walking reference model.
module tb_data_table_search_bounded;
  localparam int MAXH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_table_search_bounded_if #(.MAX_HOPS(MAXH)) bus ();

  data_table_search_bounded #(.MAX_HOPS(MAXH)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem_key  [1024];
  logic [15:0] mem_val  [1024];
  logic [9:0]  mem_next [1024];
  logic        mem_nv   [1024];

  logic [9:0] rd_log[$];
  logic [9:0] exp_reads[$];
  logic [1:0]  e_rc;
  logic [2:0]  e_cs;
  logic [2:0]  e_hops;
  logic [15:0] e_val;

  int         avail_block = 0;
  int         fixed_lat = 0;
  bit         pending = 0;
  int         cd = 0;
  logic [9:0] pend_addr = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_entry(input logic [9:0] a, input logic [31:0] k, input logic [15:0] v,
                           input logic [9:0] nxt, input logic nv);
    mem_key[a] = k; mem_val[a] = v; mem_next[a] = nxt; mem_nv[a] = nv;
  endtask

  // Reference: walk the chain as a plain loop over the memory arrays.
  task automatic model(input logic [31:0] key, input logic [9:0] head, input logic hv);
    logic [9:0] a;
    exp_reads.delete();
    e_val = '0; e_hops = '0; e_rc = 2'd1; e_cs = 3'd0;
    if (hv) begin
      a = head;
      for (int h = 1; h <= MAXH; h++) begin
        exp_reads.push_back(a);
        e_hops = 3'(h);
        if (mem_key[a] == key) begin
          e_rc = 2'd0; e_val = mem_val[a];
          e_cs = (h == 1) ? 3'd1 : (mem_nv[a] ? 3'd2 : 3'd3);
          break;
        end
        if (!mem_nv[a]) begin e_rc = 2'd1; e_cs = 3'd4; break; end
        if (h == MAXH) begin e_rc = 2'd2; e_cs = 3'd5; break; end
        a = mem_next[a];
      end
    end
  endtask

  // RAM responder: everything driven on the falling edge.
  initial begin
    bit         prev_stall = 0;
    logic [9:0] prev_addr = '0;
    bus.rd_avail_i = 1'b0; bus.rd_data_val_i = 1'b0;
    bus.rd_key_i = '0; bus.rd_value_i = '0; bus.rd_next_ptr_i = '0; bus.rd_next_ptr_val_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.rd_data_val_i = 1'b0;
      bus.rd_key_i = $urandom; bus.rd_value_i = 16'($urandom);
      bus.rd_next_ptr_i = 10'($urandom); bus.rd_next_ptr_val_i = 1'($urandom);
      if (pending) begin
        if (cd == 0) begin
          bus.rd_data_val_i = 1'b1;
          bus.rd_key_i = mem_key[pend_addr]; bus.rd_value_i = mem_val[pend_addr];
          bus.rd_next_ptr_i = mem_next[pend_addr]; bus.rd_next_ptr_val_i = mem_nv[pend_addr];
          pending = 0;
        end else cd--;
      end
      if (prev_stall && !rst) begin
        chk("rd_hold_en", 64'(bus.rd_en_o), 64'd1);
        chk("rd_hold_addr", 64'(bus.rd_addr_o), 64'(prev_addr));
      end
      if (avail_block > 0) begin bus.rd_avail_i = 1'b0; avail_block--; end
      else bus.rd_avail_i = ($urandom_range(0, 3) != 0);
      prev_stall = bus.rd_en_o && !bus.rd_avail_i && !rst;
      prev_addr  = bus.rd_addr_o;
      if (bus.rd_en_o && bus.rd_avail_i && !rst) begin
        rd_log.push_back(bus.rd_addr_o);
        pending = 1; pend_addr = bus.rd_addr_o;
        cd = ((fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3))) - 1;
      end
    end
  end

  task automatic drive_task(input logic [31:0] key, input logic [9:0] head, input logic hv,
                            input logic [9:0] bucket, input logic [3:0] tag);
    int cnt = 0;
    @(negedge clk);
    bus.task_key_i = key; bus.task_head_ptr_i = head; bus.task_head_ptr_val_i = hv;
    bus.task_bucket_i = bucket; bus.task_tag_i = tag; bus.task_valid_i = 1'b1;
    #1;
    while (!bus.task_ready_o && cnt < 50) begin @(negedge clk); #1; cnt++; end
    if (cnt >= 50) chk("accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    bus.task_valid_i = 1'b0;
    bus.task_key_i = $urandom; bus.task_head_ptr_i = 10'($urandom);
    bus.task_head_ptr_val_i = 1'($urandom); bus.task_bucket_i = 10'($urandom);
    bus.task_tag_i = 4'($urandom);
    #1;
  endtask

  task automatic run_search(input logic [31:0] key, input logic [9:0] head, input logic hv,
                            input int rdy_dly);
    logic [9:0]  bucket = 10'($urandom);
    logic [3:0]  tag = 4'($urandom);
    logic [37:0] snap;
    int cnt = 0;
    model(key, head, hv);
    rd_log.delete();
    drive_task(key, head, hv, bucket, tag);
    if (!hv) chk("nohead_latency", 64'(bus.result_valid_o), 64'd1);
    while (!bus.result_valid_o && cnt < 300) begin @(negedge clk); #1; cnt++; end
    chk("result_valid", 64'(bus.result_valid_o), 64'd1);
    snap = {bus.result_bucket_o, bus.result_tag_o, bus.result_value_o,
            bus.result_rescode_o, bus.result_chain_state_o, bus.result_hops_o};
    for (int d = 0; d < rdy_dly; d++) begin
      @(negedge clk); #1;
      chk("hold_valid", 64'(bus.result_valid_o), 64'd1);
      chk("hold_fields", 64'({bus.result_bucket_o, bus.result_tag_o, bus.result_value_o,
          bus.result_rescode_o, bus.result_chain_state_o, bus.result_hops_o}), 64'(snap));
    end
    chk("res_key", 64'(bus.result_key_o), 64'(key));
    chk("res_bucket", 64'(bus.result_bucket_o), 64'(bucket));
    chk("res_tag", 64'(bus.result_tag_o), 64'(tag));
    chk("res_rescode", 64'(bus.result_rescode_o), 64'(e_rc));
    chk("res_chain_state", 64'(bus.result_chain_state_o), 64'(e_cs));
    chk("res_hops", 64'(bus.result_hops_o), 64'(e_hops));
    chk("res_value", 64'(bus.result_value_o), 64'(e_val));
    chk("num_reads", 64'(rd_log.size()), 64'(exp_reads.size()));
    for (int i = 0; i < rd_log.size() && i < exp_reads.size(); i++)
      chk("read_addr", 64'(rd_log[i]), 64'(exp_reads[i]));
    bus.result_ready_i = 1'b1;
    @(negedge clk);
    bus.result_ready_i = 1'b0;
    #1;
    chk("result_drop", 64'(bus.result_valid_o), 64'd0);
  endtask

  initial begin
    int cnt;
    bus.task_valid_i = 1'b0; bus.task_key_i = '0; bus.task_bucket_i = '0; bus.task_tag_i = '0;
    bus.task_head_ptr_i = '0; bus.task_head_ptr_val_i = 1'b0; bus.result_ready_i = 1'b0;
    for (int i = 0; i < 1024; i++) set_entry(10'(i), 32'hFFFF_0000 | 32'(i), 16'(i), '0, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_task_ready", 64'(bus.task_ready_o), 64'd0);
    chk("rst_rd_en", 64'(bus.rd_en_o), 64'd0);
    chk("rst_result_valid", 64'(bus.result_valid_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(bus.task_ready_o), 64'd1);
    chk("post_rst_rd_addr", 64'(bus.rd_addr_o), 64'd0);
    chk("post_rst_hops", 64'(bus.result_hops_o), 64'd0);
    chk("post_rst_fields", 64'({bus.result_key_o, bus.result_value_o, bus.result_rescode_o,
        bus.result_chain_state_o}), 64'd0);

    // No head, one-entry chain, three-entry chain
    run_search(32'h0000_00A5, 10'h000, 1'b0, 2);
    set_entry(10'h010, 32'h0000_1234, 16'hBEEF, 10'h000, 1'b0);
    run_search(32'h0000_1234, 10'h010, 1'b1, 0);
    set_entry(10'h010, 32'h0000_1111, 16'hA001, 10'h020, 1'b1);
    set_entry(10'h020, 32'h0000_2222, 16'hA002, 10'h030, 1'b1);
    set_entry(10'h030, 32'h0000_3333, 16'hA003, 10'h000, 1'b0);
    run_search(32'h0000_3333, 10'h010, 1'b1, 1);
    run_search(32'h0000_2222, 10'h010, 1'b1, 0);
    run_search(32'h0000_1111, 10'h010, 1'b1, 0);
    run_search(32'h0000_4444, 10'h010, 1'b1, 0);

    // Six-entry chain versus the hop limit
    for (int j = 0; j < 6; j++)
      set_entry(10'(16'h100 + j), 32'h5000_0000 + 32'(j), 16'(16'hC000 + j),
                10'(16'h101 + j), (j < 5));
    run_search(32'h5EAD_0000, 10'h100, 1'b1, 0);
    run_search(32'h5000_0003, 10'h100, 1'b1, 0);
    run_search(32'h5000_0005, 10'h100, 1'b1, 0);

    // Read port stalled in REQ and result back-pressured
    avail_block = 8;
    run_search(32'h0000_3333, 10'h010, 1'b1, 3);

    // Reset while a read is outstanding; its data arrives afterwards
    fixed_lat = 8;
    drive_task(32'h5EAD_0000, 10'h100, 1'b1, 10'h001, 4'h1);
    cnt = 0;
    while (!pending && cnt < 50) begin @(negedge clk); #1; cnt++; end
    chk("rst_test_read_issued", 64'(pending), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(bus.task_ready_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after_rst_rd_en", 64'(bus.rd_en_o), 64'd0);
    chk("after_rst_ready", 64'(bus.task_ready_o), 64'd1);
    chk("after_rst_hops", 64'(bus.result_hops_o), 64'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      chk("after_rst_no_result", 64'({bus.result_valid_o, bus.rd_en_o}), 64'd0);
    end
    fixed_lat = 0;
    run_search(32'h0000_2222, 10'h010, 1'b1, 1);

    // Randomized chains
    for (int it = 0; it < 40; it++) begin
      int          len = int'($urandom_range(1, 7));
      logic [9:0]  base = 10'(16'h200 + it * 8);
      logic [31:0] key;
      for (int j = 0; j < len; j++)
        set_entry(base + 10'(j), $urandom, 16'($urandom), base + 10'(j + 1), (j < len - 1));
      if ($urandom_range(0, 3) == 0) key = $urandom;
      else key = mem_key[base + 10'($urandom_range(0, len - 1))];
      run_search(key, base, ($urandom_range(0, 7) != 0), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
